// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: FSM states, iteration
// count, count width and the divide-by-zero result constants.
package md_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  localparam int unsigned DIV_W    = 32;
  localparam int unsigned DIV_ITER = 32;
  localparam int unsigned CNT_W    = 6;

  // Divide by zero: quotient is all-ones, remainder is the original dividend.
  localparam logic             DIV_DZ_FILL = 1'b1;
  localparam logic [DIV_W-1:0] DIV_DZ_QUOT = {DIV_W{DIV_DZ_FILL}};

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the EX-stage issue logic and seq_divider.
//   master: drives start/is_signed/abort/dividend/divisor, sees results.
//   slave : the divider itself.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  import md_pkg::*;

  logic                 start;
  logic                 is_signed;
  logic                 abort;
  logic [WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 done;
  logic                 busy;
  logic [CNT_W-1:0]     count;

  modport master (
    output start, is_signed, abort, dividend, divisor,
    input  quotient, remainder, done, busy, count
  );

  modport slave (
    input  start, is_signed, abort, dividend, divisor,
    output quotient, remainder, done, busy, count
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration (combinational).
//   rem_i/wq_i : partial remainder and working quotient before the step
//   dvs_i      : divisor magnitude
//   rem_o/wq_o : partial remainder and working quotient after the step
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] wq_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] wq_o
);

  logic [2*WIDTH:0] sh;
  logic [WIDTH+1:0] diff;

  // Shift {rem, wq} left, trial-subtract, keep the difference if non-negative.
  always_comb begin
    sh   = {rem_i, wq_i} << 1;
    diff = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b00, dvs_i};
    if (!diff[WIDTH+1]) begin
      rem_o = diff[WIDTH:0];
      wq_o  = {sh[WIDTH-1:1], 1'b1};
    end else begin
      rem_o = sh[2*WIDTH:WIDTH];
      wq_o  = sh[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider (signed/unsigned), ITER+1 cycle latency.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of seq_divider_if (start/abort/operands in,
//           quotient/remainder/done/busy/count out, all registered)
module seq_divider
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);

  md_state_e          state_q, state_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   wq_q, wq_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               launch;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   step_wq;

  // Operand sign/magnitude; magnitudes are plain WIDTH-bit unsigned values.
  always_comb begin
    launch = bus.start && !bus.abort;
    a_neg  = bus.is_signed && bus.dividend[WIDTH-1];
    b_neg  = bus.is_signed && bus.divisor[WIDTH-1];
    a_mag  = a_neg ? -bus.dividend : bus.dividend;
    b_mag  = b_neg ? -bus.divisor  : bus.divisor;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .wq_i  (wq_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .wq_o  (step_wq)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; abort overrides everything. count_q == 2 marks the last RUN edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = RUN;
      RUN:     if (count_q == CNT_W'(2)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  // Datapath and output next values.
  always_comb begin
    rem_d       = rem_q;
    wq_d        = wq_q;
    dvs_d       = dvs_q;
    dvd_d       = dvd_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    count_d     = count_q;
    busy_d      = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          rem_d   = '0;
          wq_d    = a_mag;
          dvs_d   = b_mag;
          dvd_d   = bus.dividend;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          dz_d    = (bus.divisor == '0);
          count_d = CNT_W'(ITER + 1);
        end
      end
      RUN: begin
        rem_d   = step_rem;
        wq_d    = step_wq;
        count_d = count_q - CNT_W'(1);
      end
      FIX: begin
        if (dz_q) begin
          quotient_d  = {WIDTH{DIV_DZ_FILL}};
          remainder_d = dvd_q;
        end else begin
          quotient_d  = q_neg_q ? -wq_q : wq_q;
          remainder_d = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
        done_d  = 1'b1;
        count_d = '0;
      end
      default: ;
    endcase
    // Flush: drop the operation, keep the last published results.
    if (bus.abort) begin
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      done_d      = 1'b0;
      count_d     = '0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q       <= '0;
      wq_q        <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      rem_q       <= rem_d;
      wq_q        <= wq_d;
      dvs_q       <= dvs_d;
      dvd_q       <= dvd_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.count     = count_q;

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative radix-2 restoring divider for the EX-stage multiply/divide unit. It computes a 32-bit signed or unsigned quotient and remainder over a fixed number of cycles. Results are handed to the HI/LO result registers through a one-cycle `done` pulse. A `count` output exposes the remaining cycles so the hazard logic can stall instructions that depend on HI/LO.

## Interface
- `WIDTH`, default 32: operand and result width.
- `ITER`, default `WIDTH`: number of iteration cycles, one quotient bit per cycle.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: launch request, sampled on the rising edge.
- `is_signed` input 1: 1 = `div`, 0 = `divu`. Sampled together with `start`.
- `abort` input 1: flush request, e.g. an exception in a younger stage. Discards any operation in flight.
- `dividend` input `WIDTH`: numerator, sampled with `start`.
- `divisor` input `WIDTH`: denominator, sampled with `start`.
- `quotient` output `WIDTH`: result, destined for LO. Held until the next `done`.
- `remainder` output `WIDTH`: result, destined for HI. Held until the next `done`.
- `done` output 1: one-cycle pulse. Quotient and remainder are valid from this cycle on.
- `busy` output 1: high while an operation is in flight.
- `count` output 6: cycles remaining until `done`. 0 when idle.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - `start` with `abort` low → RUN.
  - On that edge: capture |dividend| and |divisor| (magnitudes when `is_signed`, raw values otherwise), the quotient sign (sign(dividend) xor sign(divisor)), the remainder sign (sign(dividend)), and a divide-by-zero flag.
  - Clear the 33-bit partial remainder; load `count` = `ITER`+1.
- RUN, one edge per quotient bit:
  - Shift {partial remainder, working quotient} left by 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set quotient bit 0.
  - Decrement `count`. After `ITER` edges → FIX.
- FIX, one edge:
  - Apply sign correction (two's-complement negate where the captured sign requires it).
  - Write `quotient` and `remainder`; pulse `done`; `count` → 0; → IDLE.
- Arithmetic rules:
  - Magnitudes are computed as unsigned `WIDTH`-bit values, so |0x80000000| = 0x80000000.
  - Signed overflow 0x80000000 ÷ 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 with no special case.
  - Divide by zero: iterations still run, so latency is unchanged. FIX forces quotient = all-ones and remainder = the original dividend.
- Boundary conditions:
  - `start` while `busy` is ignored; the operation in flight is unaffected.
  - `abort` in RUN or FIX → IDLE on the next edge. No `done`; `quotient`/`remainder` keep their previous values; `count` → 0.
  - `abort` together with `start` in IDLE: `abort` wins and nothing launches.
  - `start` on the edge that `done` is produced (FIX → IDLE) is ignored. A new launch is accepted from IDLE on the following edge.
  - Reset asserted mid-operation: immediately returns to IDLE with all outputs at their reset values.

## Timing
- Reset values: `quotient` = 0, `remainder` = 0, `done` = 0, `busy` = 0, `count` = 0, state IDLE.
- For `start` accepted at edge E0:
  - RUN edges are E1..E32.
  - FIX is at E33: `done` is high from E33 to E34, and results are valid from E33.
  - Latency is 33 cycles.
- `busy` is high from E0 to E33. `busy` = (state ≠ IDLE), a registered decode.
- `count` after E0 is 33, after E1 is 32, … after E32 is 1, after E33 is 0.
- `done` is never high for two consecutive cycles.
- All outputs are registered; no input reaches an output combinationally.

## Structure
- Shared package `md_pkg`:
  - state enum {IDLE, RUN, FIX};
  - `DIV_ITER` = 32;
  - the divide-by-zero result constants;
  - count width 6.
- Sub-module `div_step`: combinational single iteration. Inputs: {partial remainder, working quotient} and the divisor magnitude. Outputs: the next partial remainder and the next working quotient. It is instantiated once in RUN.
- Sign capture and negation stay in the top level.

## Test plan
- Unsigned 100 ÷ 7 with `is_signed` = 0 → `done` exactly 33 cycles after the `start` edge; quotient = 14, remainder = 2; `count` steps 33…1, then 0.
- Signed −7 ÷ 2, i.e. 0xFFFFFFF9 ÷ 0x00000002 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). The same operands unsigned → quotient 0x7FFFFFFC, remainder 1.
- Signed 0x80000000 ÷ 0xFFFFFFFF → quotient 0x80000000, remainder 0. Then any dividend ÷ 0, e.g. 0x12345678 ÷ 0 → quotient 0xFFFFFFFF, remainder 0x12345678, same latency.
- `start` with new operands at cycle 10 of a running divide → ignored; the first result is unchanged and only one `done` pulse appears.
- `abort` at cycle 20 of 1000 ÷ 3 → no `done`; `busy` = 0 and `count` = 0 on the next edge; `quotient`/`remainder` hold the prior results. A fresh `start` in the following cycle completes normally.
- `reset` driven low asynchronously mid-RUN → outputs become 0 immediately without waiting for a clock edge. After release, a 9 ÷ 3 division gives quotient 3, remainder 0.
